// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// Module  : wb_regfile_pkg
// Brief   : Shared CPU constants for the write-back stage and register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_MEM  = 2'b01;
    localparam logic [1:0] MTR_PC4  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [31:0] word_t;

    // True when an enabled write targets idx; index 0 is never a write target.
    function automatic logic wr_hits(input logic       we,
                                     input logic [4:0] dest,
                                     input logic [4:0] idx);
        return we && (dest != REG_ZERO) && (dest == idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_regfile_if.sv
// ============================================================================
// Module  : wb_regfile_if
// Brief   : Write-back and ID-stage read bus of the register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic        WB_RegWrite;
    logic [1:0]  WB_MemtoReg;
    logic [4:0]  WB_Write_register;
    word_t       WB_ALU_out;
    word_t       WB_ReadData;
    word_t       WB_PC_plus_4;
    logic [4:0]  Read_register1;
    logic [4:0]  Read_register2;
    word_t       Read_data1;
    word_t       Read_data2;
    word_t       WB_Write_data;

    modport master (
        output WB_RegWrite, WB_MemtoReg, WB_Write_register,
        output WB_ALU_out, WB_ReadData, WB_PC_plus_4,
        output Read_register1, Read_register2,
        input  Read_data1, Read_data2, WB_Write_data
    );

    modport slave (
        input  WB_RegWrite, WB_MemtoReg, WB_Write_register,
        input  WB_ALU_out, WB_ReadData, WB_PC_plus_4,
        input  Read_register1, Read_register2,
        output Read_data1, Read_data2, WB_Write_data
    );

endinterface

`default_nettype wire

// File: rtl/wb_regfile_wb_mux.sv
// ============================================================================
// Module  : wb_mux
// Brief   : Combinational write-back data select (ALU / memory / PC+4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_mux
    import wb_regfile_pkg::*;
(
    input  wire logic [1:0] i_sel,
    input  wire word_t      i_alu,
    input  wire word_t      i_mem,
    input  wire word_t      i_pc4,
    output word_t           o_data
);

    // Encoding 2'b11 is unassigned and falls back to the ALU result.
    always_comb begin
        o_data = i_alu;
        case (i_sel)
            MTR_MEM: o_data = i_mem;
            MTR_PC4: o_data = i_pc4;
            default: o_data = i_alu;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module  : wb_regfile
// Brief   : 31x32 register file with hard-wired zero, write-through bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter logic [31:0] STACK_TOP = 32'h0000_07FC,
    parameter logic [4:0]  RA_INDEX  = REG_RA
)(
    input  wire logic   clk,
    input  wire logic   reset,
    wb_regfile_if.slave bus
);

    word_t w_wdata;
    word_t w_regs [0:31];
    logic  w_byp_en;

    wb_mux u_wb_mux (
        .i_sel  (bus.WB_MemtoReg),
        .i_alu  (bus.WB_ALU_out),
        .i_mem  (bus.WB_ReadData),
        .i_pc4  (bus.WB_PC_plus_4),
        .o_data (w_wdata)
    );

    assign bus.WB_Write_data = w_wdata;
    assign w_regs[0]         = '0;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        // The link register is an ordinary register and clears like the rest.
        localparam word_t c_rst_val = (5'(i) == REG_SP)   ? STACK_TOP :
                                      (5'(i) == RA_INDEX) ? '0 : '0;
        word_t r_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_q <= c_rst_val;
            end else if (wr_hits(bus.WB_RegWrite, bus.WB_Write_register, 5'(i))) begin
                r_q <= w_wdata;
            end
        end

        assign w_regs[i] = r_q;
    end

    // Bypass is masked during reset so the ports show the reset image.
    assign w_byp_en = bus.WB_RegWrite & ~reset;

    assign bus.Read_data1 = wr_hits(w_byp_en, bus.WB_Write_register, bus.Read_register1)
                          ? w_wdata : w_regs[bus.Read_register1];
    assign bus.Read_data2 = wr_hits(w_byp_en, bus.WB_Write_register, bus.Read_register2)
                          ? w_wdata : w_regs[bus.Read_register2];

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter STACK_TOP, default 32'h0000_07FC, reset value of register 29 ($sp).
REQ-002 Parameter RA_INDEX, default 5'd31, link register index; used only for documentation and verification, no special hardware.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 WB_RegWrite  input  1  write enable from the MEM/WB register.
REQ-006 WB_MemtoReg  input  2  write-data select: 00 ALU, 01 memory, 10 PC+4, 11 ALU.
REQ-007 WB_Write_register  input  5  destination register index.
REQ-008 WB_ALU_out  input  32  ALU result.
REQ-009 WB_ReadData  input  32  data-memory load result.
REQ-010 WB_PC_plus_4  input  32  link address for jal/jalr.
REQ-011 Read_register1  input  5  ID-stage read index, port 1.
REQ-012 Read_register2  input  5  ID-stage read index, port 2.
REQ-013 Read_data1  output  32  port 1 read data.
REQ-014 Read_data2  output  32  port 2 read data.
REQ-015 WB_Write_data  output  32  selected write-back value, exported for EX forwarding.

Function
REQ-016 WB_Write_data SHALL be purely combinational from WB_MemtoReg and the three data inputs per REQ-006.
REQ-017 Storage SHALL be registers 1..31, each 32 bits; register 0 SHALL have no storage and SHALL always read 0.
REQ-018 On a rising clk edge with WB_RegWrite=1 and WB_Write_register!=0, register[WB_Write_register] SHALL load WB_Write_data; single-cycle write latency.
REQ-019 A write to index 0 SHALL be silently discarded, with no side effect on any register.
REQ-020 Read ports SHALL be combinational (zero-cycle) from the index inputs.
REQ-021 Write-through bypass: if WB_RegWrite=1, WB_Write_register!=0 and Read_registerN==WB_Write_register, Read_dataN SHALL equal WB_Write_data in the same cycle; otherwise it SHALL equal the stored value.
REQ-022 Both ports reading the same index SHALL return identical data, including the bypass case.
REQ-023 WB_RegWrite=0 SHALL leave every register unchanged regardless of the other WB inputs.
REQ-024 Reading index 0 SHALL return 0 even while a write to index 0 is pending.

Reset
REQ-025 Asserting reset SHALL immediately, without waiting for clk, clear registers 1..28 and 30..31 to 0 and set register 29 to STACK_TOP.
REQ-026 While reset=1, writes SHALL be ignored; read ports SHALL reflect the reset values.
REQ-027 After reset deasserts mid-stream, the first clk edge with WB_RegWrite=1 SHALL perform a normal write; no write is lost or replayed from before reset.
REQ-028 WB_Write_data SHALL remain combinational during reset; with the upstream MEM/WB register also in reset it evaluates to 0.

Structure
REQ-029 A shared CPU package SHALL hold the MemtoReg encodings (MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_PC4=2'b10), REG_ZERO=5'd0, REG_SP=5'd29 and REG_RA=5'd31.
REQ-030 The write-back multiplexer SHALL be a separate sub-module, wb_mux; the register array, bypass and reset logic SHALL stay in wb_regfile.

Verification
REQ-031 Reset: pulse reset mid-cycle with no clk edge -> reads of 29 = 32'h0000_07FC, reads of 5 and 31 = 0 immediately.
REQ-032 MemtoReg select: RegWrite=1, dest=8, ALU=32'h11, ReadData=32'h22, PC+4=32'h33; MemtoReg 00/01/10/11 on successive edges -> reg 8 reads 11/22/33/11.
REQ-033 Bypass: same cycle write dest=12, data=32'hDEAD_BEEF, Read_register1=Read_register2=12 -> both ports show DEADBEEF before the edge and after it.
REQ-034 Zero register: write dest=0, data=32'hFFFF_FFFF -> Read_data of index 0 = 0 before and after the edge; no other register changes.
REQ-035 Disabled write: RegWrite=0, dest=3, ALU=32'h55 -> reg 3 keeps its prior value; the next cycle with RegWrite=1 writes 55.
REQ-036 Link path: MemtoReg=10, dest=31, PC+4=32'h0040_0010 -> reg 31 reads 32'h0040_0010 after one edge.
